led_pattern_gen: RTL
====================

# led_pattern_gen

Multi-channel LED pattern generator. Successor to the single-LED fixed-rate blinker: N independent channels, each runtime-configurable as off, on, blink, or breathe (PWM ramp), with per-channel half-period in millisecond-scale ticks. Sits between the board clock and the LED pins. A simple valid/ready config port lets a host block (UART command decoder, button handler) reprogram channels.

## Interface
Parameters:
- `CHANNELS`, 4, number of LED outputs (1..16)
- `CLK_HZ`, 16000000, input clock frequency
- `TICK_HZ`, 1000, pattern tick rate; prescale `PRESCALE = CLK_HZ/TICK_HZ` (integer, ≥2)
- `PERIOD_W`, 12, width of half-period field, in ticks
- `PWM_W`, 8, breathe PWM resolution
- `DEFAULT_HALF`, 500, reset half-period (1 Hz blink at defaults)

Ports:
- `pin3_clk_16mhz` in 1, sole clock
- `rst_n` in 1, asynchronous active-low reset
- `cfg_valid` in 1, config request
- `cfg_ready` out 1, block accepts config
- `cfg_chan` in `max(1,$clog2(CHANNELS))`, target channel
- `cfg_mode` in 2, 00 OFF, 01 ON, 10 BLINK, 11 BREATHE
- `cfg_half` in `PERIOD_W`, half-period in ticks
- `tick` out 1, one-cycle pulse per tick period
- `led` out `CHANNELS`, registered LED drive, active-high

## Operation
- Reset state, all channels: mode BLINK, half = `DEFAULT_HALF`, count 0, blink state 1, duty 0, direction up. Outputs: `led` all ones, `tick` 0, `cfg_ready` 0.
- `cfg_ready` is a register that goes 1 on the first clock edge after reset release and stays 1.
- Prescaler: counts 0..`PRESCALE`-1 and wraps. `tick` is 1 for the one cycle where the count equals `PRESCALE`-1.
- Per-channel counter, advanced on `tick`. When count == eff_half−1, count goes to 0 and a "step" event fires; otherwise count+1. eff_half = max(half, 1), so half=0 behaves as 1.
- OFF: led 0. ON: led 1. Counter keeps running in both modes; it has no visible effect.
- BLINK: each step toggles blink state. led = blink state.
- BREATHE: a shared free-running `PWM_W`-bit counter advances every clock. led = (pwm_cnt < duty).
  - Each step moves duty by ±1.
  - Going up, reaching 2^PWM_W−1 flips direction to down. Going down, reaching 0 flips direction to up.
  - No overflow or underflow of duty.
- Config transfer: occurs on a rising edge where `cfg_valid && cfg_ready`. The target channel's mode and half are loaded. Its count, blink state (1), duty (0) and direction (up) are reinitialised.
- `cfg_chan` ≥ `CHANNELS`: the transfer is accepted and ignored; no state changes.
- Config transfer and a step event for the same channel on the same edge: the config transfer wins and the step is discarded. Other channels are unaffected.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously). Any in-flight config is lost.

## Timing
- Config accepted at edge N: `led` reflects the new mode at edge N+1.
- In BLINK, the first toggle follows exactly eff_half ticks after edge N.
- `led` changes on the edge after the tick that causes a step. Latency is 1 cycle.
- Blink full period = 2·eff_half·`PRESCALE` clocks.
- Breathe full cycle = 2·(2^PWM_W−1)·eff_half ticks.
- `tick` period is exactly `PRESCALE` clocks. The first `tick` comes `PRESCALE` cycles after reset release.

## Configuration
- `LED_BREATHE_EN` defined: BREATHE mode, PWM counter, and duty/direction registers are compiled in, as described above.
- `LED_BREATHE_EN` undefined: the PWM counter and duty logic are omitted, and mode 11 behaves identically to ON (led 1). All other behaviour is unchanged.

## Test plan
Bench parameters: CLK_HZ=1000, TICK_HZ=100 (PRESCALE=10), CHANNELS=4, PWM_W=4, DEFAULT_HALF=3.

- Reset release, no config:
  - `tick` every 10 clocks, first at cycle 10.
  - All `led` 1, toggling to 0 after 30 clocks and back to 1 after 60 clocks.
  - `cfg_ready` is 1 from cycle 1.
- Write ch2 OFF, ch1 ON:
  - `led[2]`=0 and `led[1]`=1 on the cycle after each accept.
  - ch0 and ch3 keep the default blink phase.
- Write ch0 BLINK half=0:
  - `led[0]` toggles every tick (10 clocks).
  - The first toggle comes exactly 1 tick after the accept.
- Write ch3 BREATHE half=1 (with `LED_BREATHE_EN`):
  - duty counts 0→15→0 over 30 ticks.
  - High-time of `led[3]` per 16-clock PWM window equals duty.
  - Without the macro, `led[3]` is steady 1.
- Config write to ch0 on the exact cycle of its step event:
  - Count and blink state restart; no toggle.
  - Next toggle comes eff_half ticks later.
- Write with `cfg_chan`=5 (2-bit field wraps? no: bench uses CHANNELS=3 variant, chan=3):
  - No state change.
- Reset asserted mid-breathe: `led` returns to all ones immediately, before any clock edge.

Source files
------------

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: per-channel OFF / ON / BLINK / BREATHE with
// a runtime half-period, reprogrammed through a valid/ready config port.
// Optional feature macro: LED_BREATHE_EN (PWM breathe mode; without it mode 11 acts as ON).
module led_pattern_gen #(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned CLK_HZ       = 16000000,
  parameter int unsigned TICK_HZ      = 1000,
  parameter int unsigned PERIOD_W     = 12,
  parameter int unsigned PWM_W        = 8,
  parameter int unsigned DEFAULT_HALF = 500,
  localparam int unsigned CHAN_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                pin3_clk_16mhz,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CHAN_W-1:0]   cfg_chan,
  input  logic [1:0]          cfg_mode,
  input  logic [PERIOD_W-1:0] cfg_half,
  output logic                tick,
  output logic [CHANNELS-1:0] led
);

  localparam int unsigned PRESCALE = CLK_HZ / TICK_HZ;
  localparam int unsigned PRE_W    = $clog2(PRESCALE);

  typedef enum logic [1:0] {
    ModeOff     = 2'b00,
    ModeOn      = 2'b01,
    ModeBlink   = 2'b10,
    ModeBreathe = 2'b11
  } mode_e;

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic                ready_q;
  mode_e               mode_q  [CHANNELS];
  mode_e               mode_d  [CHANNELS];
  logic [PERIOD_W-1:0] half_q  [CHANNELS];
  logic [PERIOD_W-1:0] half_d  [CHANNELS];
  logic [PERIOD_W-1:0] cnt_q   [CHANNELS];
  logic [PERIOD_W-1:0] cnt_d   [CHANNELS];
  logic                blink_q [CHANNELS];
  logic                blink_d [CHANNELS];
  logic [CHANNELS-1:0] led_q, led_d;
  logic [CHANNELS-1:0] step;
  logic [CHANNELS-1:0] cfg_hit;

  assign tick      = (pre_q == PRE_W'(PRESCALE - 1));
  assign cfg_ready = ready_q;
  assign led       = led_q;

  // Prescaler wraps at PRESCALE-1, which is also the tick cycle.
  always_comb begin
    pre_d = tick ? '0 : pre_q + PRE_W'(1);
  end

  // Per-channel counter, step detection and config load; a config beats a same-edge step.
  always_comb begin
    step    = '0;
    cfg_hit = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      mode_d[c]  = mode_q[c];
      half_d[c]  = half_q[c];
      cnt_d[c]   = cnt_q[c];
      blink_d[c] = blink_q[c];
      // A channel index beyond CHANNELS never matches, so such writes are dropped.
      cfg_hit[c] = cfg_valid && ready_q && (cfg_chan == CHAN_W'(c));
      // half = 0 behaves as half = 1.
      step[c]    = tick && (cnt_q[c] == ((half_q[c] == '0) ? '0 : half_q[c] - PERIOD_W'(1)));
      if (cfg_hit[c]) begin
        mode_d[c]  = mode_e'(cfg_mode);
        half_d[c]  = cfg_half;
        cnt_d[c]   = '0;
        blink_d[c] = 1'b1;
      end else if (tick) begin
        cnt_d[c] = step[c] ? '0 : cnt_q[c] + PERIOD_W'(1);
        if (step[c]) begin
          blink_d[c] = ~blink_q[c];
        end
      end
    end
  end

`ifdef LED_BREATHE_EN
  localparam logic [PWM_W-1:0] PwmMax = '1;

  logic [PWM_W-1:0] pwm_q;
  logic [PWM_W-1:0] duty_q [CHANNELS];
  logic [PWM_W-1:0] duty_d [CHANNELS];
  logic             dir_q  [CHANNELS];  // 1 = ramping down
  logic             dir_d  [CHANNELS];

  // Duty ramp: one LSB per step, turning around at full scale and at zero.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      duty_d[c] = duty_q[c];
      dir_d[c]  = dir_q[c];
      if (cfg_hit[c]) begin
        duty_d[c] = '0;
        dir_d[c]  = 1'b0;
      end else if (step[c]) begin
        if (!dir_q[c]) begin
          duty_d[c] = duty_q[c] + PWM_W'(1);
          if (duty_q[c] == PwmMax - PWM_W'(1)) dir_d[c] = 1'b1;
        end else begin
          duty_d[c] = duty_q[c] - PWM_W'(1);
          if (duty_q[c] == PWM_W'(1)) dir_d[c] = 1'b0;
        end
      end
    end
  end

  // Shared free-running PWM counter and per-channel duty/direction state.
  always_ff @(posedge pin3_clk_16mhz or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        duty_q[c] <= '0;
        dir_q[c]  <= 1'b0;
      end
    end else begin
      pwm_q <= pwm_q + PWM_W'(1);
      for (int c = 0; c < CHANNELS; c++) begin
        duty_q[c] <= duty_d[c];
        dir_q[c]  <= dir_d[c];
      end
    end
  end
`else
  logic [PWM_W-1:0] unused_pwm_w;
  assign unused_pwm_w = '0;
`endif

  // LED drive decode from the current channel state; registered one cycle later.
  always_comb begin
    led_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      case (mode_q[c])
        ModeOff:     led_d[c] = 1'b0;
        ModeOn:      led_d[c] = 1'b1;
        ModeBlink:   led_d[c] = blink_q[c];
        ModeBreathe: begin
`ifdef LED_BREATHE_EN
          led_d[c] = (pwm_q < duty_q[c]);
`else
          led_d[c] = 1'b1;
`endif
        end
      endcase
    end
  end

  // State registers.
  always_ff @(posedge pin3_clk_16mhz or negedge rst_n) begin
    if (!rst_n) begin
      pre_q   <= '0;
      ready_q <= 1'b0;
      led_q   <= '1;
      for (int c = 0; c < CHANNELS; c++) begin
        mode_q[c]  <= ModeBlink;
        half_q[c]  <= PERIOD_W'(DEFAULT_HALF);
        cnt_q[c]   <= '0;
        blink_q[c] <= 1'b1;
      end
    end else begin
      pre_q   <= pre_d;
      ready_q <= 1'b1;
      led_q   <= led_d;
      for (int c = 0; c < CHANNELS; c++) begin
        mode_q[c]  <= mode_d[c];
        half_q[c]  <= half_d[c];
        cnt_q[c]   <= cnt_d[c];
        blink_q[c] <= blink_d[c];
      end
    end
  end

endmodule
